pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the MZNM core: successor to the fixed-width D/E latch.

---
 rtl/pipe_stage_reg_pkg.sv | 19 +
 rtl/pipe_stage_reg_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: default widths,
// slot-select FSM encoding and the occupancy helper.
package pipe_stage_reg_pkg;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 24;
    localparam int PIPE_CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } slot_state_e;

    function automatic logic [1:0] occupancy(input logic head_valid, input logic skid_valid);
        return {1'b0, head_valid} + {1'b0, skid_valid};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One holding slot of the stage register: valid flag plus payload and control
// word, loaded or invalidated on the falling clock edge.
module pipe_stage_reg_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CTRL_W-1:0] wr_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Clearing drops only the valid flag so the payload stays on the bus.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= wr_data;
            ctrl  <= wr_ctrl;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid,
// flush and a shadow-squash counter that swallows in-flight beats.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                CNT_W    = PIPE_CNT_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic [CTRL_W-1:0] InCtrl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [CTRL_W-1:0] OutCtrl,
    input  logic              Flush,
    input  logic [CNT_W-1:0]  FlushNum,
    output logic [1:0]        Occupancy
);

    slot_state_e       state, state_nxt;
    logic [CNT_W-1:0]  squash_cnt;
    logic              accept, emit, squash, store;
    logic              head_load, head_clear, head_from_skid;
    logic              skid_load, skid_clear;
    logic              head_valid, skid_valid;
    logic [DATA_W-1:0] head_data, skid_data, head_wr_data;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_wr_ctrl;

    assign accept = InValid & InReady;
    assign emit   = head_valid & OutReady;
    assign squash = |squash_cnt;
    assign store  = accept & ~squash;

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (Flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
            state_nxt  = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (store) begin
                        head_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (emit && store) begin
                        head_load = 1'b1;
                    end else if (emit) begin
                        head_clear = 1'b1;
                        state_nxt  = ST_EMPTY;
                    end else if (store) begin
                        skid_load = 1'b1;
                        state_nxt = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_nxt      = ST_ONE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign head_wr_data = head_from_skid ? skid_data : InData;
    assign head_wr_ctrl = head_from_skid ? skid_ctrl : InCtrl;

    // A flush reloads the counter outright; squashing only decrements when non-zero.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_EMPTY;
            squash_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (Flush)
                squash_cnt <= FlushNum;
            else if (accept && squash)
                squash_cnt <= squash_cnt - 1'b1;
        end
    end

    pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .load    (head_load),
        .clear   (head_clear),
        .wr_data (head_wr_data),
        .wr_ctrl (head_wr_ctrl),
        .valid   (head_valid),
        .data    (head_data),
        .ctrl    (head_ctrl)
    );

    pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .wr_data (InData),
        .wr_ctrl (InCtrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );

    // Ready and occupancy come straight from slot flops: no input-to-ready path.
    assign InReady   = ~skid_valid;
    assign Occupancy = occupancy(head_valid, skid_valid);
    assign OutValid  = head_valid;
    assign OutData   = head_data;
    assign OutCtrl   = head_valid ? head_ctrl : NOP_CTRL;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, stall/skid, flush, squash,
// counter reload and asynchronous reset with a full buffer.
module tb_pipe_stage_reg;

    localparam int         DW  = 16;
    localparam int         CW  = 8;
    localparam logic [7:0] NOP = 8'hEE;

    logic          Clk = 1'b1;
    logic          Rst_n;
    logic          InValid, InReady, OutValid, OutReady, Flush;
    logic [DW-1:0] InData, OutData;
    logic [CW-1:0] InCtrl, OutCtrl;
    logic [1:0]    FlushNum, Occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(2)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .InCtrl    (InCtrl),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .OutCtrl   (OutCtrl),
        .Flush     (Flush),
        .FlushNum  (FlushNum),
        .Occupancy (Occupancy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] cw(input logic [15:0] d);
        return d[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(negedge Clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        InValid = 1'b1;
        InData  = d;
        InCtrl  = cw(d);
    endtask

    task automatic expect_beat(input string tag, input logic [15:0] d, input logic [1:0] occ);
        chk({tag, "_vld"},  32'(OutValid),  32'd1);
        chk({tag, "_data"}, 32'(OutData),   32'(d));
        chk({tag, "_ctrl"}, 32'(OutCtrl),   32'(cw(d)));
        chk({tag, "_occ"},  32'(Occupancy), 32'(occ));
    endtask

    task automatic expect_empty(input string tag);
        chk({tag, "_vld"},  32'(OutValid),  32'd0);
        chk({tag, "_ctrl"}, 32'(OutCtrl),   32'(NOP));
        chk({tag, "_occ"},  32'(Occupancy), 32'd0);
        chk({tag, "_rdy"},  32'(InReady),   32'd1);
    endtask

    initial begin
        Rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
        FlushNum = '0; InData = '0; InCtrl = '0;
        #1;
        expect_empty("rst_init");
        chk("rst_init_data", 32'(OutData), 32'd0);
        #6 Rst_n = 1'b1;
        edge_step();

        // streaming: 1..4 each one edge later, occupancy stays 1
        OutReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(16'(i));
            edge_step();
            expect_beat($sformatf("stream%0d", i), 16'(i), 2'd1);
        end
        InValid = 1'b0;
        edge_step();
        expect_empty("stream_drain");
        chk("stream_hold_data", 32'(OutData), 32'd4);

        // stall: A in head, B into skid, C held upstream
        OutReady = 1'b0;
        send(16'h00A0);
        edge_step();
        expect_beat("stall_a", 16'h00A0, 2'd1);
        chk("stall_a_rdy", 32'(InReady), 32'd1);
        send(16'h00B0);
        edge_step();
        expect_beat("stall_b_in", 16'h00A0, 2'd2);
        chk("stall_b_rdy", 32'(InReady), 32'd0);
        send(16'h00C0);
        edge_step();
        expect_beat("stall_c_held", 16'h00A0, 2'd2);
        chk("stall_c_rdy", 32'(InReady), 32'd0);
        OutReady = 1'b1;
        edge_step();
        expect_beat("stall_out_b", 16'h00B0, 2'd1);
        chk("stall_out_b_rdy", 32'(InReady), 32'd1);
        edge_step();
        expect_beat("stall_out_c", 16'h00C0, 2'd1);
        InValid = 1'b0;
        edge_step();
        expect_empty("stall_drain");

        // flush with full buffer, FlushNum=0, beat D offered
        OutReady = 1'b0;
        send(16'h0021);
        edge_step();
        send(16'h0022);
        edge_step();
        chk("flush_pre_occ", 32'(Occupancy), 32'd2);
        send(16'h000D);
        Flush = 1'b1; FlushNum = 2'd0;
        edge_step();
        Flush = 1'b0; InValid = 1'b0;
        expect_empty("flush");
        edge_step();
        expect_empty("flush_d_dropped");
        OutReady = 1'b1;
        send(16'h000E);
        edge_step();
        expect_beat("flush_no_squash", 16'h000E, 2'd1);

        // squash: FlushNum=2 drops E and F, delivers G
        InValid = 1'b0;
        Flush = 1'b1; FlushNum = 2'd2;
        edge_step();
        Flush = 1'b0;
        expect_empty("sq_flush");
        send(16'h0031);
        edge_step();
        expect_empty("sq_drop_e");
        send(16'h0032);
        edge_step();
        expect_empty("sq_drop_f");
        send(16'h0033);
        edge_step();
        expect_beat("sq_g", 16'h0033, 2'd1);
        InValid = 1'b0;
        edge_step();

        // reload: FlushNum=3, one drop, then FlushNum=1 replaces the remainder
        Flush = 1'b1; FlushNum = 2'd3;
        edge_step();
        Flush = 1'b0;
        send(16'h0041);
        edge_step();
        expect_empty("rl_drop1");
        InValid = 1'b0;
        Flush = 1'b1; FlushNum = 2'd1;
        edge_step();
        Flush = 1'b0;
        send(16'h0042);
        edge_step();
        expect_empty("rl_drop2");
        send(16'h0043);
        edge_step();
        expect_beat("rl_deliver", 16'h0043, 2'd1);
        InValid = 1'b0;
        edge_step();

        // asynchronous reset with two beats held, checked before any clock edge
        OutReady = 1'b0;
        send(16'h0051);
        edge_step();
        send(16'h0052);
        edge_step();
        expect_beat("arst_pre", 16'h0051, 2'd2);
        #2 Rst_n = 1'b0;
        #1;
        expect_empty("arst");
        chk("arst_data", 32'(OutData), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
